// File: rtl/bit_serial_alu_if.sv
// Request/response bundle for bit_serial_alu.
//   slave  : the ALU side (accepts a, b, alu_ctrl; returns result and flags)
//   master : the requester/consumer side
// Signals: in_valid/in_ready request handshake, a/b operands (two's complement),
// alu_ctrl {ainvert, binvert, op[1:0]}, out_valid/out_ready result handshake,
// result, zero, overflow, carry_out.
interface bit_serial_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             carry_out;

    modport slave (
        input  in_valid, a, b, alu_ctrl, out_ready,
        output in_ready, out_valid, result, zero, overflow, carry_out
    );

    modport master (
        output in_valid, a, b, alu_ctrl, out_ready,
        input  in_ready, out_valid, result, zero, overflow, carry_out
    );
endinterface

// File: rtl/bit_serial_alu.sv
// Bit-serial MIPS-style ALU: one 1-bit slice reused for WIDTH cycles, LSB first.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : bit_serial_alu_if.slave (request handshake, operands, alu_ctrl,
//           result handshake, result, zero, overflow, carry_out)
// Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR; any other
// code completes with result 0 and zero set. Result is valid WIDTH cycles after
// the accepting edge and is held until out_valid && out_ready.
module bit_serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    bit_serial_alu_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic [3:0]       ctrl;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-2:0] acc;        // result bits 0..WIDTH-2, collected LSB first
    logic [WIDTH-1:0] result_q;
    logic             zero_q, ovf_q, cout_q;

    logic             is_msb;
    logic             ai, bi, s_sum, s_cout, s_out;
    logic             msb_ovf, set_bit;
    logic [WIDTH-1:0] acc_full;
    logic [WIDTH-1:0] fin_res;
    logic             fin_ovf, fin_cout;

    assign is_msb = (cnt == CW'(WIDTH - 1));

    // 1-bit slice
    always_comb begin
        ai     = a_sh[0] ^ ctrl[3];
        bi     = b_sh[0] ^ ctrl[2];
        s_sum  = ai ^ bi ^ carry;
        s_cout = (ai & bi) | (ai & carry) | (bi & carry);
        s_out  = 1'b0;                     // op 3 "less" input is 0 above the LSB
        case (ctrl[1:0])
            2'd0:    s_out = ai & bi;
            2'd1:    s_out = ai | bi;
            2'd2:    s_out = s_sum;
            default: s_out = 1'b0;
        endcase
        msb_ovf  = carry ^ s_cout;
        set_bit  = s_sum ^ msb_ovf;
        acc_full = {s_out, acc};
    end

    // Final result/flags, only meaningful on the MSB cycle. SLT's set bit is
    // known only at the MSB, so the LSB is patched here instead of in-flight.
    always_comb begin
        fin_res  = '0;
        fin_ovf  = 1'b0;
        fin_cout = 1'b0;
        case (ctrl)
            CTRL_ADD, CTRL_SUB: begin
                fin_res  = acc_full;
                fin_ovf  = msb_ovf;
                fin_cout = s_cout;
            end
            CTRL_AND, CTRL_OR, CTRL_NOR: fin_res = acc_full;
            CTRL_SLT: fin_res[0] = set_bit;
            default: fin_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_next = RUN;
            RUN:     if (is_msb)        state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs; handshakes are forced low while reset is asserted
    always_comb begin
        bus.in_ready  = rst_n && (state == IDLE);
        bus.out_valid = rst_n && (state == DONE);
        bus.result    = result_q;
        bus.zero      = zero_q;
        bus.overflow  = ovf_q;
        bus.carry_out = cout_q;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            ctrl     <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            acc      <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        ctrl  <= bus.alu_ctrl;
                        cnt   <= '0;
                        carry <= bus.alu_ctrl[2];
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= s_cout;
                    cnt   <= cnt + CW'(1);
                    acc   <= acc_full[WIDTH-1:1];
                    if (is_msb) begin
                        result_q <= fin_res;
                        zero_q   <= (fin_res == '0);
                        ovf_q    <= fin_ovf;
                        cout_q   <= fin_cout;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_alu.sv
module tb_bit_serial_alu;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         ov;
        logic         co;
    } exp_t;

    typedef struct {
        logic [3:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         z;
        logic         ov;
        logic         co;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    bit_serial_alu_if #(.WIDTH(W)) bus ();

    bit_serial_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model from arithmetic definitions
    function automatic exp_t model(logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b);
        exp_t r;
        int sa, sb, s;
        int smax, smin;
        logic [W:0] u;
        sa   = $signed(a);
        sb   = $signed(b);
        smax = (1 << (W - 1)) - 1;
        smin = -(1 << (W - 1));
        r    = '0;
        case (c)
            4'b0000: r.res = a & b;
            4'b0001: r.res = a | b;
            4'b0010: begin
                s     = sa + sb;
                u     = {1'b0, a} + {1'b0, b};
                r.res = u[W-1:0];
                r.co  = u[W];
                r.ov  = (s > smax) || (s < smin);
            end
            4'b0110: begin
                s     = sa - sb;
                r.res = a - b;
                r.co  = (a >= b);
                r.ov  = (s > smax) || (s < smin);
            end
            4'b0111: r.res = (sa < sb) ? W'(1) : W'(0);
            4'b1100: r.res = ~(a | b);
            default: r.res = '0;
        endcase
        r.z = (r.res == '0);
        return r;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b);
        int k;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            tick();
            k++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.alu_ctrl = c;
        tick();
        // operands need not stay stable after acceptance
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.alu_ctrl = 4'($urandom);
    endtask

    task automatic wait_done();
        repeat (W - 1) tick();
        check("lat_early", 32'(bus.out_valid), 32'd0);
        tick();
        check("lat_valid", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic check_result(string tag, exp_t e);
        check({tag, "_res"}, 32'(bus.result), 32'(e.res));
        check({tag, "_zero"}, 32'(bus.zero), 32'(e.z));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(e.ov));
        check({tag, "_cout"}, 32'(bus.carry_out), 32'(e.co));
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("hs_valid_low", 32'(bus.out_valid), 32'd0);
        check("hs_ready_high", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        vec_t         dq[$];
        exp_t         e, e2;
        logic [3:0]   codes[6];
        logic [3:0]   c;
        logic [W-1:0] ra, rb;
        logic         saw_valid;

        n_assert      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.alu_ctrl  = '0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_result("rst", '{res: '0, z: 1'b1, ov: 1'b0, co: 1'b0});
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", 32'(bus.in_ready), 32'd1);

        // Directed vectors: {ctrl, a, b, result, zero, overflow, carry_out}
        dq.push_back('{4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0});
        dq.push_back('{4'b0110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1});
        dq.push_back('{4'b0010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1});
        dq.push_back('{4'b0111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0});
        dq.push_back('{4'b0111, 8'h7F, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0});
        dq.push_back('{4'b0000, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0, 1'b0});
        dq.push_back('{4'b0001, 8'hCC, 8'hAA, 8'hEE, 1'b0, 1'b0, 1'b0});
        dq.push_back('{4'b1100, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0});
        dq.push_back('{4'b1111, 8'h5A, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b0});
        foreach (dq[i]) begin
            do_accept(dq[i].c, dq[i].a, dq[i].b);
            wait_done();
            check_result("dir", '{res: dq[i].r, z: dq[i].z, ov: dq[i].ov, co: dq[i].co});
            handshake();
        end

        // Backpressure in DONE, then no accept on the handshake edge
        e = model(4'b0010, 8'h12, 8'h34);
        do_accept(4'b0010, 8'h12, 8'h34);
        wait_done();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            bus.alu_ctrl = 4'($urandom);
            tick();
            check_result("bp_hold", e);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b1;
        bus.a         = 8'h40;
        bus.b         = 8'h03;
        bus.alu_ctrl  = 4'b0110;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_idle_ready", 32'(bus.in_ready), 32'd1);
        check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        check("bp_accepted", 32'(bus.in_ready), 32'd0);
        wait_done();
        check_result("bp_next", model(4'b0110, 8'h40, 8'h03));
        handshake();

        // Reset on the 4th RUN cycle aborts the operation
        do_accept(4'b0010, 8'h55, 8'h22);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("abort_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("abort_valid_low", 32'(bus.out_valid), 32'd0);
        check_result("abort_rst", '{res: '0, z: 1'b1, ov: 1'b0, co: 1'b0});
        rst_n = 1'b1;
        #1;
        check("abort_release_ready", 32'(bus.in_ready), 32'd1);
        saw_valid = 1'b0;
        repeat (W + 4) begin
            tick();
            saw_valid = saw_valid | bus.out_valid;
        end
        check("abort_never_valid", 32'(saw_valid), 32'd0);

        // Reset while in DONE
        do_accept(4'b0001, 8'h0F, 8'h30);
        wait_done();
        rst_n = 1'b0;
        tick();
        check("done_rst_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        check("done_rst_valid2", 32'(bus.out_valid), 32'd0);
        check("done_rst_ready", 32'(bus.in_ready), 32'd1);

        // Random operations against the model
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) c = 4'($urandom);
            else                           c = codes[$urandom_range(0, 5)];
            ra = W'($urandom);
            rb = W'($urandom);
            e2 = model(c, ra, rb);
            do_accept(c, ra, rb);
            wait_done();
            repeat ($urandom_range(0, 2)) tick();
            check_result("rand", e2);
            handshake();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/bit_serial_alu.md
BIT_SERIAL_ALU -- requirements
Module: bit_serial_alu

Interface
REQ-001 Parameter SHALL be: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 Port SHALL be: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port SHALL be: rst_n  input  1  synchronous, active-low reset (sampled on clk rising edge).
REQ-004 Port SHALL be: in_valid  input  1  request present on a, b, alu_ctrl.
REQ-005 Port SHALL be: in_ready  output  1  block can accept a request.
REQ-006 Port SHALL be: a  input  WIDTH  operand A, two's complement.
REQ-007 Port SHALL be: b  input  WIDTH  operand B, two's complement.
REQ-008 Port SHALL be: alu_ctrl  input  4  {ainvert, binvert, op[1:0]}.
REQ-009 Port SHALL be: out_valid  output  1  result and flags valid.
REQ-010 Port SHALL be: out_ready  input  1  consumer accepts result.
REQ-011 Port SHALL be: result  output  WIDTH  operation result.
REQ-012 Port SHALL be: zero  output  1  result == 0.
REQ-013 Port SHALL be: overflow  output  1  signed overflow (ADD/SUB only).
REQ-014 Port SHALL be: carry_out  output  1  carry out of MSB (ADD/SUB only).

Function
REQ-015 Supported alu_ctrl codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR; any other code completes normally with result 0, overflow 0, carry_out 0, zero 1.
REQ-016 Datapath SHALL be one 1-bit ALU slice reused per cycle: operands inverted per ainvert/binvert, op 0 AND, 1 OR, 2 sum, 3 less input.
REQ-017 FSM SHALL have states IDLE, RUN, DONE; reset state is IDLE.
REQ-018 in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE).
REQ-019 On an edge with in_valid && in_ready, a, b and alu_ctrl SHALL be captured into shift registers, bit counter cleared, carry register loaded with binvert, and state moved to RUN.
REQ-020 In RUN, one bit SHALL be processed per cycle, LSB first; bit i of the result is produced on the (i+1)th edge after acceptance.
REQ-021 Carry register SHALL hold the slice carry between bits; slice carryIn for bit 0 equals binvert.
REQ-022 At the MSB bit, overflow SHALL be carry-into-MSB XOR carry-out-of-MSB, and set SHALL be MSB sum XOR overflow.
REQ-023 For SLT, result SHALL be {(WIDTH-1) zeros, set}; overflow and carry_out SHALL be 0.
REQ-024 For AND/OR/NOR, overflow and carry_out SHALL be 0.
REQ-025 After the MSB edge (WIDTH edges after acceptance), state SHALL be DONE; out_valid latency is exactly WIDTH cycles.
REQ-026 In DONE, result, zero, overflow and carry_out SHALL hold stable until out_valid && out_ready on an edge, then state returns to IDLE.
REQ-027 in_valid SHALL be ignored in RUN and DONE; a new request cannot be accepted in the same cycle as the output handshake.
REQ-028 Operand inputs SHALL not be required stable after the acceptance edge.

Reset
REQ-029 When rst_n is low at a rising edge, state SHALL become IDLE, counter 0, carry 0, result 0, zero 1, overflow 0, carry_out 0.
REQ-030 Reset in RUN or DONE SHALL abort the operation; out_valid is 0 on the next cycle and the aborted result is never presented.
REQ-031 While rst_n is low, in_ready and out_valid SHALL be 0.

Verification (WIDTH = 8)
REQ-032 ADD a=0x7F b=0x01 -> result 0x80, overflow 1, carry_out 0, zero 0, out_valid exactly 8 cycles after accept edge.
REQ-033 SUB a=0x05 b=0x05 -> result 0x00, zero 1, carry_out 1, overflow 0; ADD 0xFF+0x01 -> result 0x00, carry_out 1, overflow 0.
REQ-034 SLT a=0x80 b=0x01 -> result 0x01; SLT a=0x7F b=0x80 (internal overflow) -> result 0x00; overflow 0 in both.
REQ-035 Logic: AND 0xCC,0xAA -> 0x88; OR 0xCC,0xAA -> 0xEE; NOR 0xF0,0x0F -> 0x00, zero 1; code 1111 -> result 0x00, zero 1.
REQ-036 Backpressure: hold out_ready 0 for 3 cycles in DONE while toggling in_valid and operands -> outputs unchanged, in_ready 0; out_ready 1 -> IDLE next cycle, then next request accepted.
REQ-037 Assert rst_n low on 4th RUN cycle -> next cycle state IDLE, in_ready 1 after release, out_valid never asserted for aborted request.
